// File: rtl/efpga_config_packer.sv
// rtl/efpga_config_packer.sv - packs USB configuration bytes into 32-bit eFPGA self-write words
//
// Hunts for SYNC_WORD in the byte stream, then assembles big-endian words and
// emits each as a one-cycle write strobe, keeping at least STROBE_GAP idle
// cycles between strobes. A partial word that stalls for TIMEOUT_CYCLES is dropped.
// Optional feature macro: PACKER_WORD_COUNT_EN (adds word_count_o).
//
// Ports:
//   clk_system_i          sole clock, rising edge
//   reset_i               synchronous active-high reset
//   byte_data_i/valid_i   incoming configuration byte and its valid
//   byte_ready_o          packer accepts a byte this cycle
//   abort_i               drop partial/pending word, return to HUNT
//   efpga_write_data_o    last emitted word (registered)
//   efpga_write_strobe_o  one-cycle write pulse
//   session_active_o      high from sync-word emission until abort/timeout/reset
//   timeout_o             one-cycle pulse when a stalled partial word is dropped
//   word_count_o          strobes in current session (macro builds only)

module efpga_config_packer #(
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
    parameter int          STROBE_GAP     = 2,
    parameter int          TIMEOUT_CYCLES = 12_000
) (
    input  logic        clk_system_i,
    input  logic        reset_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        abort_i,
    output logic [31:0] efpga_write_data_o,
    output logic        efpga_write_strobe_o,
    output logic        session_active_o,
    output logic        timeout_o
`ifdef PACKER_WORD_COUNT_EN
    ,
    output logic [15:0] word_count_o
`endif
);

    localparam int          TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  GAP          = 5'(STROBE_GAP);

    typedef enum logic [1:0] {HUNT, LOAD, EMIT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   pending_q, pending_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    idx_q, idx_d;
    logic [4:0]    gap_q, gap_d;
    logic [TW-1:0] stall_q, stall_d;
    logic          sess_q, sess_d;
    logic          strobe_q, strobe_d;
    logic          timeout_q, timeout_d;
    logic          accept;
    logic          strobe_fire;
    logic          gap_ok_next;
    logic [31:0]   shifted;
`ifdef PACKER_WORD_COUNT_EN
    logic [15:0]   count_q, count_d;
`endif

    assign byte_ready_o         = ~reset_i & (state_q != EMIT);
    assign accept               = byte_valid_i & byte_ready_o;
    // The strobe is registered one cycle ahead so it lands in the cycle after the
    // 4th byte; abort and reset can still suppress it in the cycle it would show.
    assign strobe_fire          = strobe_q & ~abort_i & ~reset_i;
    assign efpga_write_strobe_o = strobe_fire;
    assign efpga_write_data_o   = data_q;
    assign session_active_o     = sess_q;
    assign timeout_o            = timeout_q;
    assign shifted              = {shift_q[23:0], byte_data_i};
`ifdef PACKER_WORD_COUNT_EN
    assign word_count_o         = count_q;
`endif

    // gap_d is the gap count seen next cycle; a strobe may be scheduled for next
    // cycle once that count reaches STROBE_GAP.
    assign gap_d       = strobe_fire ? 5'd0 : ((gap_q >= GAP) ? GAP : gap_q + 5'd1);
    assign gap_ok_next = (gap_d >= GAP);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pending_d = pending_q;
        data_d    = data_q;
        idx_d     = idx_q;
        stall_d   = stall_q;
        sess_d    = sess_q;
        strobe_d  = 1'b0;
        timeout_d = 1'b0;
`ifdef PACKER_WORD_COUNT_EN
        count_d   = (strobe_fire && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
`endif
        case (state_q)
            HUNT: begin
                if (accept) begin
                    shift_d = shifted;
                    if (shifted == SYNC_WORD) begin
                        pending_d = SYNC_WORD;
                        shift_d   = 32'd0;
                        sess_d    = 1'b1;
                        state_d   = EMIT;
                        if (gap_ok_next) begin
                            strobe_d = 1'b1;
                            data_d   = SYNC_WORD;
                        end
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shift_d = shifted;
                    stall_d = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        pending_d = shifted;
                        state_d   = EMIT;
                        if (gap_ok_next) begin
                            strobe_d = 1'b1;
                            data_d   = shifted;
                        end
                    end
                end else if (idx_q != 2'd0) begin
                    if (stall_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = HUNT;
                        shift_d   = 32'd0;
                        pending_d = 32'd0;
                        idx_d     = 2'd0;
                        stall_d   = '0;
                        sess_d    = 1'b0;
`ifdef PACKER_WORD_COUNT_EN
                        count_d   = 16'd0;
`endif
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (strobe_q) begin
                    state_d = LOAD;
                end else if (gap_ok_next) begin
                    strobe_d = 1'b1;
                    data_d   = pending_q;
                end
            end
            default: state_d = HUNT;
        endcase

        if (abort_i) begin
            state_d   = HUNT;
            shift_d   = 32'd0;
            pending_d = 32'd0;
            idx_d     = 2'd0;
            stall_d   = '0;
            sess_d    = 1'b0;
            strobe_d  = 1'b0;
            timeout_d = 1'b0;
            data_d    = data_q;
`ifdef PACKER_WORD_COUNT_EN
            count_d   = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk_system_i) begin
        if (reset_i) begin
            state_q   <= HUNT;
            shift_q   <= 32'd0;
            pending_q <= 32'd0;
            data_q    <= 32'd0;
            idx_q     <= 2'd0;
            gap_q     <= GAP;
            stall_q   <= '0;
            sess_q    <= 1'b0;
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
`ifdef PACKER_WORD_COUNT_EN
            count_q   <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            stall_q   <= stall_d;
            sess_q    <= sess_d;
            strobe_q  <= strobe_d;
            timeout_q <= timeout_d;
`ifdef PACKER_WORD_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_efpga_config_packer.sv
// tb/tb_efpga_config_packer.sv - directed self-checking bench for efpga_config_packer

module tb_efpga_config_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bdata;
    logic        bvalid;
    logic        abort;
    logic        ready;
    logic [31:0] wdata;
    logic        strobe;
    logic        session;
    logic        timeout;

    logic [7:0]  g_data;
    logic        g_valid;
    logic        g_abort;
    logic        g_ready;
    logic [31:0] g_wdata;
    logic        g_strobe;
    logic        g_session;
    logic        g_timeout;

`ifdef PACKER_WORD_COUNT_EN
    logic [15:0] wcount;
    logic [15:0] g_wcount;
`endif

    always #5 clk = ~clk;

    efpga_config_packer u_dut (
        .clk_system_i         (clk),
        .reset_i              (reset),
        .byte_data_i          (bdata),
        .byte_valid_i         (bvalid),
        .byte_ready_o         (ready),
        .abort_i              (abort),
        .efpga_write_data_o   (wdata),
        .efpga_write_strobe_o (strobe),
        .session_active_o     (session),
        .timeout_o            (timeout)
`ifdef PACKER_WORD_COUNT_EN
        ,
        .word_count_o         (wcount)
`endif
    );

    efpga_config_packer #(.STROBE_GAP(7)) u_gap (
        .clk_system_i         (clk),
        .reset_i              (reset),
        .byte_data_i          (g_data),
        .byte_valid_i         (g_valid),
        .byte_ready_o         (g_ready),
        .abort_i              (g_abort),
        .efpga_write_data_o   (g_wdata),
        .efpga_write_strobe_o (g_strobe),
        .session_active_o     (g_session),
        .timeout_o            (g_timeout)
`ifdef PACKER_WORD_COUNT_EN
        ,
        .word_count_o         (g_wcount)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] s_data[$];
    int          s_cyc[$];
    int          t_cnt = 0;
    int          t_cyc = 0;
    logic [31:0] g_sd[$];
    int          g_sc[$];
    int          g_rdy_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (strobe) begin
            s_data.push_back(wdata);
            s_cyc.push_back(cyc);
        end
        if (timeout) begin
            t_cnt = t_cnt + 1;
            t_cyc = cyc;
        end
        if (g_strobe) begin
            g_sd.push_back(g_wdata);
            g_sc.push_back(cyc);
            if (g_ready) g_rdy_bad = g_rdy_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called just after a rising edge; returns the cycle stamp of the transfer cycle.
    task automatic send(input bit sel, input logic [7:0] b, output int acc);
        bit done;
        done = 1'b0;
        acc  = -100;
        if (sel) begin g_data = b; g_valid = 1'b1; end
        else     begin bdata  = b; bvalid  = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel && g_ready) || (!sel && ready)) begin
                acc  = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        g_valid = 1'b0;
        bvalid  = 1'b0;
        if (!done) check("handshake_bound", 32'(done), 32'd1);
    endtask

    task automatic send4(input bit sel, input logic [31:0] w, output int acc);
        logic [31:0] v;
        v = w;
        send(sel, v[31:24], acc);
        send(sel, v[23:16], acc);
        send(sel, v[15:8],  acc);
        send(sel, v[7:0],   acc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    int acc, acc_sync;

    initial begin
        reset = 1'b1; bdata = 8'h00; bvalid = 1'b0; abort = 1'b0;
        g_data = 8'h00; g_valid = 1'b0; g_abort = 1'b0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_strobe",  32'(strobe),  32'd0);
        check("rst_session", 32'(session), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_data",    wdata,        32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'd1);
        @(posedge clk); #1;

        // sync then one data word, gap already satisfied
        s_data.delete(); s_cyc.delete();
        send4(1'b0, 32'hFAB0_FAB1, acc_sync);
        send4(1'b0, 32'h0000_002A, acc);
        idle(3);
        check("a_nstrobes", 32'(s_data.size()), 32'd2);
        if (s_data.size() >= 2) begin
            check("a_data0", s_data[0], 32'hFAB0_FAB1);
            check("a_data1", s_data[1], 32'h0000_002A);
            check("a_lat0",  32'(s_cyc[0]), 32'(acc_sync + 1));
            check("a_lat1",  32'(s_cyc[1]), 32'(acc + 1));
        end
        check("a_session", 32'(session), 32'd1);
        check("a_hold",    wdata, 32'h0000_002A);
`ifdef PACKER_WORD_COUNT_EN
        check("a_count", 32'(wcount), 32'd2);
`endif
        pulse_abort();
        @(negedge clk);
        check("a_abort_session", 32'(session), 32'd0);
        @(posedge clk); #1;

        // garbage ahead of the sync word
        s_data.delete(); s_cyc.delete();
        send(1'b0, 8'h11, acc);
        send(1'b0, 8'h22, acc);
        send4(1'b0, 32'hFAB0_FAB1, acc);
        idle(3);
        check("b_nstrobes", 32'(s_data.size()), 32'd1);
        if (s_data.size() >= 1) begin
            check("b_data", s_data[0], 32'hFAB0_FAB1);
            check("b_lat",  32'(s_cyc[0]), 32'(acc + 1));
        end
        check("b_session", 32'(session), 32'd1);

        // sync word inside a session is plain data
        s_data.delete(); s_cyc.delete();
        send4(1'b0, 32'hFAB0_FAB1, acc);
        idle(3);
        check("c_nstrobes", 32'(s_data.size()), 32'd1);
        if (s_data.size() >= 1) check("c_data", s_data[0], 32'hFAB0_FAB1);
        check("c_session", 32'(session), 32'd1);

        // stall inside a partial word
        s_data.delete(); s_cyc.delete();
        t_cnt = 0;
        send(1'b0, 8'hAA, acc);
        send(1'b0, 8'hBB, acc);
        idle(12_010);
        check("d_timeouts",  32'(t_cnt), 32'd1);
        check("d_to_cycle",  32'(t_cyc), 32'(acc + 12_001));
        check("d_nstrobes",  32'(s_data.size()), 32'd0);
        check("d_session",   32'(session), 32'd0);
`ifdef PACKER_WORD_COUNT_EN
        check("d_count", 32'(wcount), 32'd0);
`endif
        send4(1'b0, 32'h0000_002A, acc);
        idle(3);
        check("d_hunt_nostrobe", 32'(s_data.size()), 32'd0);

        // abort together with the 4th byte
        send4(1'b0, 32'hFAB0_FAB1, acc);
        send4(1'b0, 32'h1122_3344, acc);
        send4(1'b0, 32'h5566_7788, acc);
        idle(3);
        check("e_nstrobes", 32'(s_data.size()), 32'd3);
        if (s_data.size() >= 3) begin
            check("e_data1", s_data[1], 32'h1122_3344);
            check("e_data2", s_data[2], 32'h5566_7788);
        end
`ifdef PACKER_WORD_COUNT_EN
        check("e_count3", 32'(wcount), 32'd3);
`endif
        s_data.delete(); s_cyc.delete();
        send(1'b0, 8'h01, acc);
        send(1'b0, 8'h02, acc);
        send(1'b0, 8'h03, acc);
        bdata = 8'h04; bvalid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        bvalid = 1'b0; abort = 1'b0;
        idle(4);
        check("e_abort_nostrobe", 32'(s_data.size()), 32'd0);
        check("e_abort_session",  32'(session), 32'd0);
`ifdef PACKER_WORD_COUNT_EN
        check("e_count0", 32'(wcount), 32'd0);
`endif
        send4(1'b0, 32'hFAB0_FAB1, acc);
        idle(3);
        check("e_restart_n", 32'(s_data.size()), 32'd1);
        if (s_data.size() >= 1) check("e_restart_data", s_data[0], 32'hFAB0_FAB1);
        check("e_restart_session", 32'(session), 32'd1);

        // reset in the middle of a word
        s_data.delete(); s_cyc.delete();
        send(1'b0, 8'h01, acc);
        send(1'b0, 8'h02, acc);
        send(1'b0, 8'h03, acc);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("f_session", 32'(session), 32'd0);
        check("f_data",    wdata, 32'd0);
        @(posedge clk); #1;
        send(1'b0, 8'h04, acc);
        idle(3);
        check("f_nostrobe", 32'(s_data.size()), 32'd0);

        // streaming into the STROBE_GAP=7 instance: strobes 8 cycles apart
        send4(1'b1, 32'hFAB0_FAB1, acc_sync);
        send4(1'b1, 32'h1234_5678, acc);
        send4(1'b1, 32'h9ABC_DEF0, acc);
        send4(1'b1, 32'h0F1E_2D3C, acc);
        idle(12);
        check("g_nstrobes", 32'(g_sd.size()), 32'd4);
        if (g_sd.size() >= 4) begin
            check("g_lat0",  32'(g_sc[0]), 32'(acc_sync + 1));
            check("g_data1", g_sd[1], 32'h1234_5678);
            check("g_data2", g_sd[2], 32'h9ABC_DEF0);
            check("g_data3", g_sd[3], 32'h0F1E_2D3C);
            check("g_gap1",  32'(g_sc[1] - g_sc[0]), 32'd8);
            check("g_gap2",  32'(g_sc[2] - g_sc[1]), 32'd8);
            check("g_gap3",  32'(g_sc[3] - g_sc[2]), 32'd8);
        end
        check("g_ready_in_emit", 32'(g_rdy_bad), 32'd0);
        check("g_session", 32'(g_session), 32'd1);
`ifdef PACKER_WORD_COUNT_EN
        check("g_count", 32'(g_wcount), 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/efpga_config_packer.md
EFPGA_CONFIG_PACKER -- requirements
Module: efpga_config_packer

Interface
REQ-001 Parameter SYNC_WORD, default 32'hFAB0_FAB1, word that opens a configuration session.
REQ-002 Parameter STROBE_GAP, default 2, minimum idle cycles between two write strobes (range 0..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 12_000, byte-stall limit inside a partial word (1 ms at 12 MHz); minimum 1.
REQ-004 clk_system_i  input  1  sole clock; all logic on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 byte_data_i  input  8  configuration byte from the USB controller's receive side.
REQ-007 byte_valid_i  input  1  byte_data_i holds a valid byte.
REQ-008 byte_ready_o  output  1  packer accepts a byte this cycle; transfer occurs when valid and ready are both high.
REQ-009 abort_i  input  1  drop any partial or pending word and return to HUNT.
REQ-010 efpga_write_data_o  output  32  assembled word, feeds the eFPGA SelfWriteData port.
REQ-011 efpga_write_strobe_o  output  1  one-cycle pulse, feeds SelfWriteStrobe.
REQ-012 session_active_o  output  1  high from sync-word emission until abort, timeout or reset.
REQ-013 timeout_o  output  1  one-cycle pulse when a partial word is discarded on stall.

Function
REQ-014 States: HUNT, LOAD and EMIT; reset state is HUNT.
REQ-015 Byte order: big-endian. The first byte of a word goes to bits [31:24].
REQ-016 HUNT: byte_ready_o=1, and each accepted byte shifts into a 32-bit register (new byte goes to [7:0]).
REQ-017 HUNT: when the shift register, including the just-accepted byte, equals SYNC_WORD, the packer loads SYNC_WORD as the pending word, sets session_active_o the next cycle and enters EMIT.
REQ-018 LOAD: byte_ready_o=1, and a 2-bit byte index counts accepted bytes 0..3.
REQ-019 LOAD: acceptance of the 4th byte enters EMIT with the word pending, and the byte index wraps to 0.
REQ-020 EMIT: byte_ready_o=0 and the gap counter is checked. If fewer than STROBE_GAP cycles have passed since the last strobe, the packer waits.
REQ-021 EMIT strobe: otherwise it drives efpga_write_strobe_o=1 for exactly one cycle with efpga_write_data_o = pending word, then enters LOAD.
REQ-022 Latency with STROBE_GAP satisfied: the strobe is asserted in the cycle after the 4th byte is accepted.
REQ-023 efpga_write_data_o is registered and holds the last emitted word between strobes.
REQ-024 Gap counter: saturating at STROBE_GAP, cleared in the strobe cycle; STROBE_GAP=0 allows back-to-back strobes.
REQ-025 Timeout, LOAD only: with byte index nonzero, a stall counter increments on every cycle with no accepted byte.
REQ-026 Timeout action: at TIMEOUT_CYCLES the packer pulses timeout_o, discards the partial word, clears session_active_o and returns to HUNT with the shift register cleared.
REQ-027 Timeout counter: cleared on every accepted byte. It does not run in HUNT, in EMIT, or in LOAD with byte index 0.
REQ-028 abort_i (any state): next cycle is HUNT with index, shift register and pending word cleared and session_active_o=0, and no strobe is issued. abort_i outranks a simultaneous 4th byte, strobe or timeout.
REQ-029 In LOAD, a word equal to SYNC_WORD is forwarded as ordinary data and does not restart the session.

Reset
REQ-030 reset_i high, sampled on clk_system_i, forces HUNT and sets every output to 0, except byte_ready_o, which is 0 during reset and 1 in the first cycle after release.
REQ-031 Reset mid-word or mid-EMIT discards the pending data with no strobe; reset outranks abort_i.

Configuration
REQ-032 Macro PACKER_WORD_COUNT_EN.
REQ-033 With the macro defined, the block adds output word_count_o (16 bits): the number of strobes in the current session, including the sync word. It saturates at 16'hFFFF, clears on reset/abort/timeout, and updates the cycle after each strobe.
REQ-034 Without the macro, the port and counter are absent, and all other behaviour is identical.

Verification
REQ-035 Bytes FA B0 FA B1 00 00 00 2A, STROBE_GAP=2 -> strobes with data 32'hFAB0_FAB1 then 32'h0000_002A; the second strobe comes the cycle after byte 2A, and session_active_o=1.
REQ-036 Garbage 11 22 FA B0 FA B1 -> no strobe before the 6th byte, exactly one strobe of SYNC_WORD after it.
REQ-037 Sync word, then bytes AA BB, then valid low for 12_000 cycles -> timeout_o pulses once, no strobe for AA BB, session_active_o=0, state HUNT.
REQ-038 Continuous valid for 3 words after sync, STROBE_GAP=3 -> byte_ready_o low in EMIT and strobes spaced at least 4 cycles apart, with all data in order.
REQ-039 abort_i asserted in the same cycle as the 4th byte -> no strobe, session_active_o=0, and the next FA B0 FA B1 restarts the session.
REQ-040 With PACKER_WORD_COUNT_EN: sync plus 2 words -> word_count_o=3; after abort_i -> 0.
